iwrr_grant_sequencer: RTL and testbench
=======================================

Name: iwrr_grant_sequencer

Overview:
- Producer side of the interleaved weighted round-robin (IWRR) arbiter.
- Owns the sub-round index and the scan pointer, and issues one-hot grants with a valid/ready handshake.
- Drives the grant and sub-round index consumed by the round-completion logic, and generates its own round-completion pulse.
- Sits between the requester bank and the downstream grant consumer.

Parameters:
- P_REQUESTER_NUM, 3: number of requesters.
- P_WEIGHT_W, 2: bit width of each requester weight and of the sub-round index.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_i  input  P_REQUESTER_NUM  request vector; bit n = requester n.
- req_weight_i  input  [0:P_REQUESTER_NUM*P_WEIGHT_W-1]  packed weights; requester n occupies bits n*P_WEIGHT_W to (n+1)*P_WEIGHT_W-1.
- grant_ready_i  input  1  downstream accepts the current grant.
- grant_valid_o  output  1  grant_o is valid.
- grant_o  output  P_REQUESTER_NUM  one-hot grant; zero when grant_valid_o=0.
- num_grant_req_o  output  P_WEIGHT_W  current sub-round index r.
- round_comp_o  output  1  one-cycle pulse: the round has wrapped.

Behaviour:
- Reset (asynchronous, any time, including mid-handshake): all outputs and all state cleared.
  - grant_valid_o=0, grant_o=0, num_grant_req_o=0, round_comp_o=0, ptr=0.
  - Weight snapshot cleared; FSM=LOAD.
- Weight snapshot wsnap:
  - Loaded from req_weight_i in LOAD, and in the cycle round_comp_o is set.
  - Changes to req_weight_i mid-round are ignored.
  - max_w = maximum of wsnap entries.
- Eligibility: requester n is eligible in sub-round r iff req_i[n]=1 and wsnap[n] > r. Comparison is unsigned, P_WEIGHT_W bits.
- FSM states:
  - LOAD: capture wsnap; go to ARB next cycle.
  - ARB: evaluate eligibility for indices n >= ptr.
    - If any eligible: select the lowest such n, register grant_o = one-hot(n) and grant_valid_o=1, go to GRANT. Grant latency is 1 cycle from ARB.
    - Else if req_i=0 or max_w=0: stay in ARB; r unchanged; no grant.
    - Else (sub-round exhausted): ptr<=0, advance r (see below), stay in ARB. Costs one bubble cycle per skipped sub-round.
  - GRANT: grant_o and grant_valid_o held stable while grant_ready_i=0. req_i changes are ignored while in GRANT.
    - On handshake (grant_valid_o & grant_ready_i): grant_valid_o<=0, grant_o<=0, ptr<=g+1, go to ARB.
    - If no requester with index > g is eligible in sub-round r, also ptr<=0 and advance r.
- Advance r:
  - If r == max_w-1: r<=0, round_comp_o<=1 for exactly one cycle, and wsnap reloaded.
  - Else: r<=r+1.
- ptr overflow: ptr is P_REQUESTER_NUM-range; g = P_REQUESTER_NUM-1 always exhausts the sub-round.
- Simultaneous events:
  - A handshake that exhausts the final sub-round pulses round_comp_o in the same cycle grant_valid_o falls.
  - A new grant cannot issue in that cycle; the earliest next grant is 1 cycle later.
- num_grant_req_o is the registered value of r. It remains valid during GRANT and reflects the sub-round of the held grant.

Optional Feature:
- Macro: IWRR_ROUND_CNT_EN.
- Defined:
  - Adds output round_cnt_o (8 bits).
  - Increments, wrapping at 255, in the same cycle round_comp_o is set.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Nominal round:
   - Stimulus: weights {r0=1, r1=3, r2=2}, req_i=3'b111, grant_ready_i=1.
   - Required grants, in order: 001,010,100,010,100,010.
   - num_grant_req_o for each grant: 0,0,0,1,1,2.
   - round_comp_o pulses once, with the 6th handshake; the pattern then repeats.
2. Backpressure:
   - Stimulus: same setup, grant_ready_i=0 for 3 cycles while grant_o=3'b010.
   - Required: grant_o and grant_valid_o stay stable for all 3 cycles.
   - On ready=1: exactly one handshake; the next grant is 3'b100.
3. Zero weight:
   - Stimulus: weights {0,2,0}, req_i=3'b111.
   - Required: only 3'b010 is ever granted, twice per round (r=0,1); round_comp_o after every 2nd handshake.
4. Sub-round skip:
   - Stimulus: weights {1,3,2}, req_i=3'b001.
   - Required: grant 001 at r=0, then two bubble cycles (r=1, r=2) with no grant.
   - round_comp_o pulses on the wrap to r=0, then 001 is granted again.
5. Weight change mid-round:
   - Stimulus: change r0 weight from 1 to 3 after the first grant.
   - Required: the current round is unaffected; the new weight applies only after round_comp_o.
6. Reset mid-GRANT:
   - Stimulus: assert rst_n=0 asynchronously while grant_valid_o=1.
   - Required: grant_valid_o and grant_o go to 0 immediately; num_grant_req_o=0.
   - After release: LOAD, then the first grant goes to the lowest eligible index at r=0.

Source files
------------

// File: rtl/iwrr_grant_sequencer.sv
//------------------------------------------------------------------------------
// Module      : iwrr_grant_sequencer
// Description : Producer side of an interleaved weighted round-robin arbiter.
//               Owns the sub-round index r and the scan pointer, and issues
//               one-hot grants over a valid/ready handshake. A requester n is
//               eligible in sub-round r when it requests and its snapshotted
//               weight is strictly greater than r. When a sub-round runs out
//               of eligible requesters, r advances. When r wraps, a one-cycle
//               round-completion pulse is produced and the weights are
//               re-snapshotted.
// Optional    : `define IWRR_ROUND_CNT_EN adds an 8-bit wrapping round counter
//               output (round_cnt_o).
// Ports       :
//   clk             in   clock, all state on rising edge
//   rst_n           in   asynchronous active-low reset
//   req_i           in   request vector, bit n = requester n
//   req_weight_i    in   packed weights, requester n at [n*W +: W]
//   grant_ready_i   in   downstream accepts the current grant
//   grant_valid_o   out  grant_o is valid
//   grant_o         out  one-hot grant, zero when not valid
//   num_grant_req_o out  current sub-round index r (registered)
//   round_comp_o    out  one-cycle pulse when the round wraps
//   round_cnt_o     out  completed-round counter (IWRR_ROUND_CNT_EN only)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module iwrr_grant_sequencer #(
  parameter int P_REQUESTER_NUM = 3,
  parameter int P_WEIGHT_W      = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [P_REQUESTER_NUM-1:0]             req_i,
  input  logic [0:P_REQUESTER_NUM*P_WEIGHT_W-1]  req_weight_i,
  input  logic                                   grant_ready_i,
  output logic                                   grant_valid_o,
  output logic [P_REQUESTER_NUM-1:0]             grant_o,
  output logic [P_WEIGHT_W-1:0]                  num_grant_req_o,
  output logic                                   round_comp_o
`ifdef IWRR_ROUND_CNT_EN
  ,
  output logic [7:0]                             round_cnt_o
`endif
);

  localparam int c_PTR_W = (P_REQUESTER_NUM > 1) ? $clog2(P_REQUESTER_NUM) : 1;
  localparam logic [P_WEIGHT_W-1:0] c_ONE_W   = {{(P_WEIGHT_W-1){1'b0}}, 1'b1};
  localparam logic [c_PTR_W-1:0]    c_ONE_PTR = {{(c_PTR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_ARB   = 2'd1,
    S_GRANT = 2'd2
  } state_t;

  // Registered state
  state_t                        r_state;
  logic [P_WEIGHT_W-1:0]         r_wsnap [P_REQUESTER_NUM];
  logic [P_WEIGHT_W-1:0]         r_round;
  logic [c_PTR_W-1:0]            r_ptr;
  logic [c_PTR_W-1:0]            r_gidx;
  logic                          r_grant_valid;
  logic [P_REQUESTER_NUM-1:0]    r_grant;
  logic                          r_round_comp;
`ifdef IWRR_ROUND_CNT_EN
  logic [7:0]                    r_round_cnt;
`endif

  // Combinational decode
  logic [P_WEIGHT_W-1:0]         w_weight_in [P_REQUESTER_NUM];
  logic [P_REQUESTER_NUM-1:0]    w_elig;
  logic [P_WEIGHT_W-1:0]         w_max_w;
  logic                          w_arb_hit;
  logic [c_PTR_W-1:0]            w_arb_idx;
  logic [P_REQUESTER_NUM-1:0]    w_arb_onehot;
  logic                          w_above_any;
  logic                          w_handshake;
  logic                          w_arb_exhausted;
  logic                          w_advance;
  logic                          w_last_sub;
  logic                          w_wrap;

  // Unpack the flat weight bus into one entry per requester.
  generate
    for (genvar gi = 0; gi < P_REQUESTER_NUM; gi++) begin : g_unpack
      assign w_weight_in[gi] = req_weight_i[gi*P_WEIGHT_W +: P_WEIGHT_W];
    end
  endgenerate

  always_comb begin
    w_elig  = '0;
    w_max_w = '0;
    for (int n = 0; n < P_REQUESTER_NUM; n++) begin
      w_elig[n] = req_i[n] && (r_wsnap[n] > r_round);
      if (r_wsnap[n] > w_max_w) begin
        w_max_w = r_wsnap[n];
      end
    end
  end

  // Lowest eligible index at or above the scan pointer. The loop runs
  // downward so the last hit written is the lowest index.
  always_comb begin
    w_arb_hit    = 1'b0;
    w_arb_idx    = '0;
    w_arb_onehot = '0;
    for (int n = P_REQUESTER_NUM - 1; n >= 0; n--) begin
      if (w_elig[n] && (n >= int'(r_ptr))) begin
        w_arb_hit       = 1'b1;
        w_arb_idx       = c_PTR_W'(n);
        w_arb_onehot    = '0;
        w_arb_onehot[n] = 1'b1;
      end
    end
  end

  // Is anyone above the held grant still eligible in this sub-round?
  always_comb begin
    w_above_any = 1'b0;
    for (int n = 0; n < P_REQUESTER_NUM; n++) begin
      if (w_elig[n] && (n > int'(r_gidx))) begin
        w_above_any = 1'b1;
      end
    end
  end

  assign w_handshake     = (r_state == S_GRANT) && r_grant_valid && grant_ready_i;
  // Requests exist and some weight is non-zero, yet nobody remains eligible
  // from the pointer up: the sub-round is finished and costs one bubble.
  assign w_arb_exhausted = (r_state == S_ARB) && !w_arb_hit &&
                           (req_i != '0) && (w_max_w != '0);
  assign w_advance       = w_arb_exhausted || (w_handshake && !w_above_any);
  assign w_last_sub      = (r_round == (w_max_w - c_ONE_W));
  assign w_wrap          = w_advance && w_last_sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_LOAD;
      r_round       <= '0;
      r_ptr         <= '0;
      r_gidx        <= '0;
      r_grant_valid <= 1'b0;
      r_grant       <= '0;
      r_round_comp  <= 1'b0;
      for (int n = 0; n < P_REQUESTER_NUM; n++) begin
        r_wsnap[n] <= '0;
      end
`ifdef IWRR_ROUND_CNT_EN
      r_round_cnt   <= 8'd0;
`endif
    end else begin
      r_round_comp <= w_wrap;

      case (r_state)
        S_LOAD: begin
          r_round <= '0;
          r_ptr   <= '0;
          r_state <= S_ARB;
        end

        S_ARB: begin
          if (w_arb_hit) begin
            r_grant_valid <= 1'b1;
            r_grant       <= w_arb_onehot;
            r_gidx        <= w_arb_idx;
            r_state       <= S_GRANT;
          end else if (w_arb_exhausted) begin
            r_ptr <= '0;
          end
        end

        S_GRANT: begin
          if (w_handshake) begin
            r_grant_valid <= 1'b0;
            r_grant       <= '0;
            r_state       <= S_ARB;
            // The last requester always exhausts the sub-round, so the
            // incremented pointer never leaves the requester range.
            r_ptr         <= w_above_any ? (r_gidx + c_ONE_PTR) : '0;
          end
        end

        default: begin
          r_grant_valid <= 1'b0;
          r_grant       <= '0;
          r_state       <= S_LOAD;
        end
      endcase

      // Sub-round advance shared by the ARB bubble and the exhausting handshake.
      if (w_advance) begin
        r_round <= w_last_sub ? '0 : (r_round + c_ONE_W);
      end

      // Weights are sampled only at round boundaries so that a round is
      // always scheduled against one consistent weight set.
      if ((r_state == S_LOAD) || w_wrap) begin
        for (int n = 0; n < P_REQUESTER_NUM; n++) begin
          r_wsnap[n] <= w_weight_in[n];
        end
      end

`ifdef IWRR_ROUND_CNT_EN
      if (w_wrap) begin
        r_round_cnt <= r_round_cnt + 8'd1;
      end
`endif
    end
  end

  assign grant_valid_o   = r_grant_valid;
  assign grant_o         = r_grant;
  assign num_grant_req_o = r_round;
  assign round_comp_o    = r_round_comp;
`ifdef IWRR_ROUND_CNT_EN
  assign round_cnt_o     = r_round_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_iwrr_grant_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_iwrr_grant_sequencer
// Description : Scoreboard bench for iwrr_grant_sequencer. Stimulus pushes the
//               hand-computed grant sequence into a queue; a monitor pops and
//               compares on every accepted grant.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_iwrr_grant_sequencer;

  localparam int N = 3;
  localparam int W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [0:N*W-1]   weight = '0;
  logic             ready = 1'b0;
  logic             grant_valid;
  logic [N-1:0]     grant;
  logic [W-1:0]     num_grant_req;
  logic             round_comp;
`ifdef IWRR_ROUND_CNT_EN
  logic [7:0]       round_cnt;
`endif

  always #5 clk = ~clk;

  iwrr_grant_sequencer #(
    .P_REQUESTER_NUM (N),
    .P_WEIGHT_W      (W)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_i           (req),
    .req_weight_i    (weight),
    .grant_ready_i   (ready),
    .grant_valid_o   (grant_valid),
    .grant_o         (grant),
    .num_grant_req_o (num_grant_req),
    .round_comp_o    (round_comp)
`ifdef IWRR_ROUND_CNT_EN
    ,
    .round_cnt_o     (round_cnt)
`endif
  );

  typedef struct {
    logic [N-1:0] g;
    logic [W-1:0] r;
    logic         rc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;

  int n_cmp    = 0;
  int n_err    = 0;
  int hs_count = 0;
  int rc_count = 0;
  int cyc      = 0;
  int last_hs  = 0;
  int prev_hs  = 0;
  logic pend_v  = 1'b0;
  logic pend_rc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [0:N*W-1] pack(input int a, input int b, input int c);
    logic [0:N*W-1] v;
    v = '0;
    v[0 +: W]   = W'(a);
    v[W +: W]   = W'(b);
    v[2*W +: W] = W'(c);
    return v;
  endfunction

  task automatic push(input logic [N-1:0] g, input logic [W-1:0] r, input logic rc);
    exp_t e;
    e.g = g; e.r = r; e.rc = rc;
    exp_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, i.e. the values the next rising
  // edge will act on.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pend_v = 1'b0;
    end else begin
      if (pend_v) begin
        chk("round_comp_after_hs", 32'(round_comp), 32'(pend_rc));
        pend_v = 1'b0;
      end
      if (round_comp) rc_count++;
      if (!grant_valid) chk("grant_zero_when_idle", 32'(grant), 32'd0);
      else              chk("grant_onehot", 32'($onehot(grant)), 32'd1);
      if (grant_valid && ready) begin
        hs_count++;
        prev_hs = last_hs;
        last_hs = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_grant: got %b expected none", grant);
        end else begin
          e_mon = exp_q.pop_front();
          chk("grant", 32'(grant), 32'(e_mon.g));
          chk("subround", 32'(num_grant_req), 32'(e_mon.r));
          pend_v  = 1'b1;
          pend_rc = e_mon.rc;
        end
      end
    end
  end

  task automatic do_reset(input logic [0:N*W-1] w, input logic [N-1:0] r);
    rst_n  = 1'b0;
    ready  = 1'b0;
    weight = w;
    req    = r;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_hs(input int n, input int budget);
    int target;
    bit ok;
    target = hs_count + n;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (hs_count >= target) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL handshake_timeout: got %0d expected %0d", hs_count, target);
    end
  endtask

  task automatic wait_valid(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (grant_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL valid_timeout: got 0 expected 1");
    end
  endtask

  task automatic accept_one();
    wait_valid(20);
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic end_phase(input string name);
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  int rc_base;

  initial begin
    // 1: nominal round, back-to-back acceptance, two full rounds
    do_reset(pack(1, 3, 2), 3'b111);
    chk("reset_valid", 32'(grant_valid), 32'd0);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_subround", 32'(num_grant_req), 32'd0);
    chk("reset_round_comp", 32'(round_comp), 32'd0);
    rc_base = rc_count;
    for (int k = 0; k < 2; k++) begin
      push(3'b001, 2'd0, 1'b0);
      push(3'b010, 2'd0, 1'b0);
      push(3'b100, 2'd0, 1'b0);
      push(3'b010, 2'd1, 1'b0);
      push(3'b100, 2'd1, 1'b0);
      push(3'b010, 2'd2, 1'b1);
    end
    ready = 1'b1;
    wait_hs(12, 100);
    ready = 1'b0;
    @(negedge clk); #1;
    chk("p1_round_comp_count", 32'(rc_count - rc_base), 32'd2);
    chk("p1_b2b_spacing", 32'(last_hs - prev_hs), 32'd2);
    end_phase("p1_queue_drained");

    // 2: backpressure holds grant 010 stable for 3 cycles
    do_reset(pack(1, 3, 2), 3'b111);
    push(3'b001, 2'd0, 1'b0);
    accept_one();
    wait_valid(20);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("p2_hold_valid", 32'(grant_valid), 32'd1);
      chk("p2_hold_grant", 32'(grant), 32'b010);
    end
    push(3'b010, 2'd0, 1'b0);
    accept_one();
    push(3'b100, 2'd0, 1'b0);
    accept_one();
    end_phase("p2_queue_drained");

    // 3: zero weights on r0 and r2
    do_reset(pack(0, 2, 0), 3'b111);
    rc_base = rc_count;
    push(3'b010, 2'd0, 1'b0);
    push(3'b010, 2'd1, 1'b1);
    push(3'b010, 2'd0, 1'b0);
    push(3'b010, 2'd1, 1'b1);
    ready = 1'b1;
    wait_hs(4, 60);
    ready = 1'b0;
    @(negedge clk); #1;
    chk("p3_round_comp_count", 32'(rc_count - rc_base), 32'd2);
    end_phase("p3_queue_drained");

    // 4: sub-round skip with only requester 0 active
    do_reset(pack(1, 3, 2), 3'b001);
    rc_base = rc_count;
    push(3'b001, 2'd0, 1'b0);
    push(3'b001, 2'd0, 1'b0);
    ready = 1'b1;
    wait_hs(2, 60);
    ready = 1'b0;
    chk("p4_bubble_spacing", 32'(last_hs - prev_hs), 32'd4);
    chk("p4_round_comp_count", 32'(rc_count - rc_base), 32'd1);
    end_phase("p4_queue_drained");

    // 5: weight change mid-round takes effect only at the next round
    do_reset(pack(1, 3, 2), 3'b111);
    rc_base = rc_count;
    push(3'b001, 2'd0, 1'b0);
    ready = 1'b1;
    wait_hs(1, 20);
    weight = pack(3, 3, 2);
    push(3'b010, 2'd0, 1'b0);
    push(3'b100, 2'd0, 1'b0);
    push(3'b010, 2'd1, 1'b0);
    push(3'b100, 2'd1, 1'b0);
    push(3'b010, 2'd2, 1'b1);
    push(3'b001, 2'd0, 1'b0);
    push(3'b010, 2'd0, 1'b0);
    push(3'b100, 2'd0, 1'b0);
    push(3'b001, 2'd1, 1'b0);
    push(3'b010, 2'd1, 1'b0);
    push(3'b100, 2'd1, 1'b0);
    push(3'b001, 2'd2, 1'b0);
    push(3'b010, 2'd2, 1'b1);
    wait_hs(13, 120);
    ready = 1'b0;
    @(negedge clk); #1;
    chk("p5_round_comp_count", 32'(rc_count - rc_base), 32'd2);
    end_phase("p5_queue_drained");

    // 6: asynchronous reset while a sub-round-1 grant is held
    do_reset(pack(1, 3, 2), 3'b111);
    push(3'b001, 2'd0, 1'b0);
    push(3'b010, 2'd0, 1'b0);
    push(3'b100, 2'd0, 1'b0);
    accept_one();
    accept_one();
    accept_one();
    wait_valid(20);
    chk("p6_pre_grant", 32'(grant), 32'b010);
    chk("p6_pre_subround", 32'(num_grant_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("p6_async_valid", 32'(grant_valid), 32'd0);
    chk("p6_async_grant", 32'(grant), 32'd0);
    chk("p6_async_subround", 32'(num_grant_req), 32'd0);
    req = 3'b110;
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("p6_load_no_grant", 32'(grant_valid), 32'd0);
    @(posedge clk); #1;
    chk("p6_first_valid", 32'(grant_valid), 32'd1);
    chk("p6_first_grant", 32'(grant), 32'b010);
    chk("p6_first_subround", 32'(num_grant_req), 32'd0);
    push(3'b010, 2'd0, 1'b0);
    accept_one();
    @(negedge clk); #1;
    end_phase("p6_queue_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
